cmos_gate_driver: RTL and testbench

//  Multi-channel CMOS output-stage gate driver with break-before-make dead-time insertion.

---
 rtl/cmos_gate_driver.sv | 111 +++++++++++
 tb/tb_cmos_gate_driver.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_gate_driver.sv
`default_nettype none
// ============================================================================
// cmos_gate_driver : multi-channel push-pull gate driver with break-before-make
// dead time. Optional switch-level pad node: define CMOS_SWITCH_PAD_EN.
// Revision: 1.0
// ============================================================================
module cmos_gate_driver #(
    parameter int WIDTH       = 4,
    parameter int DEAD_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_req_i,
    input  logic [WIDTH-1:0] tri_en_i,
    output logic [WIDTH-1:0] pg_o,
    output logic [WIDTH-1:0] ng_o,
    output logic [WIDTH-1:0] busy_o
`ifdef CMOS_SWITCH_PAD_EN
    ,
    output wire  [WIDTH-1:0] pad_o
`endif
);

    localparam int CNT_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DEAD = 2'd3
    } state_e;

    if (DEAD_CYCLES < 1 || WIDTH < 1) begin : g_param_check
        $error("cmos_gate_driver: WIDTH and DEAD_CYCLES must both be >= 1");
    end

`ifdef CMOS_SWITCH_PAD_EN
    supply1 vdd;
    supply0 gnd;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pg_q, ng_q, busy_q;

        // Inputs are only looked at outside DEAD, so request chatter cannot shorten it.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_OFF: begin
                    if (!tri_en_i[i]) begin
                        state_d = in_req_i[i] ? S_HIGH : S_LOW;
                    end
                end
                S_LOW: begin
                    if (tri_en_i[i] || in_req_i[i]) begin
                        state_d = S_DEAD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_HIGH: begin
                    if (tri_en_i[i] || !in_req_i[i]) begin
                        state_d = S_DEAD;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_DEAD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (tri_en_i[i]) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = in_req_i[i] ? S_HIGH : S_LOW;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end

        // Gate outputs are decoded from the next state so they switch on the same edge as it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_OFF;
                cnt_q   <= '0;
                pg_q    <= 1'b1;
                ng_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pg_q    <= (state_d != S_HIGH);
                ng_q    <= (state_d == S_LOW);
                busy_q  <= (state_d == S_DEAD);
            end
        end

        assign pg_o[i]   = pg_q;
        assign ng_o[i]   = ng_q;
        assign busy_o[i] = busy_q;

`ifdef CMOS_SWITCH_PAD_EN
        pmos u_pmos (pad_o[i], vdd, pg_q);
        nmos u_nmos (pad_o[i], gnd, ng_q);
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_cmos_gate_driver.sv
`default_nettype none
// tb_cmos_gate_driver : scoreboard bench for cmos_gate_driver (WIDTH=4, DEAD_CYCLES=3).
// Reference model runs on every rising edge; monitor compares on the falling edge.
module tb_cmos_gate_driver;

    localparam int W      = 4;
    localparam int DC     = 3;
    localparam int M_OFF  = 0;
    localparam int M_LOW  = 1;
    localparam int M_HIGH = 2;
    localparam int M_DEAD = 3;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic [W-1:0] in_req = '0;
    logic [W-1:0] tri_en = '1;
    logic [W-1:0] pg, ng, busy;
`ifdef CMOS_SWITCH_PAD_EN
    wire  [W-1:0] pad;
`endif

    int checks   = 0;
    int failures = 0;
    bit sb_en    = 1'b0;

    int m_state[W];
    int m_el[W];

    typedef struct packed {
        logic [W-1:0] pg;
        logic [W-1:0] ng;
        logic [W-1:0] busy;
        logic [W-1:0] pad;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cmos_gate_driver #(
        .WIDTH      (W),
        .DEAD_CYCLES(DC)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_req_i(in_req),
        .tri_en_i(tri_en),
        .pg_o    (pg),
        .ng_o    (ng),
        .busy_o  (busy)
`ifdef CMOS_SWITCH_PAD_EN
        ,
        .pad_o   (pad)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < W; i++) begin
            m_state[i] = M_OFF;
            m_el[i]    = 0;
        end
    endfunction

    // m_el counts dead cycles already spent, independent of the RTL down-counter.
    function automatic void model_step();
        for (int i = 0; i < W; i++) begin
            case (m_state[i])
                M_OFF:  if (!tri_en[i]) m_state[i] = in_req[i] ? M_HIGH : M_LOW;
                M_LOW:  if (tri_en[i] || in_req[i]) begin m_state[i] = M_DEAD; m_el[i] = 1; end
                M_HIGH: if (tri_en[i] || !in_req[i]) begin m_state[i] = M_DEAD; m_el[i] = 1; end
                default: begin
                    if (m_el[i] < DC) m_el[i] = m_el[i] + 1;
                    else m_state[i] = tri_en[i] ? M_OFF : (in_req[i] ? M_HIGH : M_LOW);
                end
            endcase
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.pg[i]   = (m_state[i] != M_HIGH);
            e.ng[i]   = (m_state[i] == M_LOW);
            e.busy[i] = (m_state[i] == M_DEAD);
            e.pad[i]  = (m_state[i] == M_HIGH) ? 1'b1 : (m_state[i] == M_LOW) ? 1'b0 : 1'bz;
        end
        return e;
    endfunction

    always @(negedge rst_n) model_reset();

    initial forever begin
        @(posedge clk);
        if (sb_en) begin
            if (!rst_n) model_reset();
            else model_step();
            exp_q.push_back(model_out());
        end
    end

    initial forever begin
        @(negedge clk);
        if (sb_en) begin
            checks++;
            if ((~pg & ng) !== '0) begin
                failures++;
                $display("FAIL shoot_through: pg=%b ng=%b", pg, ng);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({pg, ng, busy} !== {mon_e.pg, mon_e.ng, mon_e.busy}) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: pg/ng/busy got %b/%b/%b expected %b/%b/%b",
                             $time, pg, ng, busy, mon_e.pg, mon_e.ng, mon_e.busy);
                end
`ifdef CMOS_SWITCH_PAD_EN
                checks++;
                if (pad !== mon_e.pad) begin
                    failures++;
                    $display("FAIL scoreboard_pad t=%0t: got %b expected %b", $time, pad, mon_e.pad);
                end
`endif
            end
        end
    end

    task automatic test_reset();
        #3;
        rst_n = 1'b0;
        sb_en = 1'b1;
        #1;
        checks++;
        if (pg !== 4'hF) begin failures++; $display("FAIL reset_pg: got %h expected f", pg); end
        checks++;
        if (ng !== 4'h0) begin failures++; $display("FAIL reset_ng: got %h expected 0", ng); end
        checks++;
        if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy: got %h expected 0", busy); end
`ifdef CMOS_SWITCH_PAD_EN
        checks++;
        if (pad !== 4'bzzzz) begin failures++; $display("FAIL reset_pad: got %b expected zzzz", pad); end
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pg, ng, busy} !== {4'hF, 4'h0, 4'h0}) begin
            failures++;
            $display("FAIL reset_hold: pg/ng/busy got %h/%h/%h expected f/0/0", pg, ng, busy);
        end
    endtask

    task automatic test_startup();
        @(negedge clk);
        in_req = 4'b0101;
        tri_en = 4'b0000;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({pg, ng, busy} !== {4'b1010, 4'b1010, 4'b0000}) begin
            failures++;
            $display("FAIL startup: pg/ng/busy got %b/%b/%b expected 1010/1010/0000", pg, ng, busy);
        end
    endtask

    task automatic test_dead_time();
        @(negedge clk);
        in_req = 4'b0100;
        for (int k = 1; k <= DC; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy[0], pg[0], ng[0]} !== 3'b110) begin
                failures++;
                $display("FAIL dead_cycle%0d: busy/pg/ng got %b expected 110", k, {busy[0], pg[0], ng[0]});
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({pg, ng, busy} !== {4'b1011, 4'b1011, 4'b0000}) begin
            failures++;
            $display("FAIL dead_exit_low: pg/ng/busy got %b/%b/%b expected 1011/1011/0000", pg, ng, busy);
        end
    endtask

    task automatic test_mid_dead_toggle();
        @(negedge clk);
        in_req = 4'b0101;
        repeat (DC + 1) @(posedge clk);
        #1;
        checks++;
        if ({busy[0], pg[0], ng[0]} !== 3'b000) begin
            failures++;
            $display("FAIL toggle_setup_high: busy/pg/ng got %b expected 000", {busy[0], pg[0], ng[0]});
        end
        @(negedge clk);
        in_req[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL toggle_dead1: busy got %b expected 1", busy[0]); end
        @(negedge clk);
        in_req[0] = 1'b1;
        for (int k = 2; k <= DC; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy[0], pg[0], ng[0]} !== 3'b110) begin
                failures++;
                $display("FAIL toggle_dead%0d: busy/pg/ng got %b expected 110", k, {busy[0], pg[0], ng[0]});
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy[0], pg[0], ng[0]} !== 3'b000) begin
            failures++;
            $display("FAIL toggle_back_high: busy/pg/ng got %b expected 000", {busy[0], pg[0], ng[0]});
        end
    endtask

    task automatic test_hiz();
        @(negedge clk);
        tri_en = 4'b0010;
        for (int k = 1; k <= DC + 2; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busy[1], pg[1], ng[1]} !== ((k <= DC) ? 3'b110 : 3'b010)) begin
                failures++;
                $display("FAIL hiz_edge%0d: busy/pg/ng got %b expected %b", k, {busy[1], pg[1], ng[1]},
                         (k <= DC) ? 3'b110 : 3'b010);
            end
        end
`ifdef CMOS_SWITCH_PAD_EN
        checks++;
        if (pad[1] !== 1'bz) begin failures++; $display("FAIL hiz_pad: got %b expected z", pad[1]); end
`endif
        @(negedge clk);
        tri_en = 4'b0000;
        in_req = 4'b0111;
        @(posedge clk);
        #1;
        checks++;
        if ({busy[1], pg[1], ng[1]} !== 3'b000) begin
            failures++;
            $display("FAIL hiz_release_high: busy/pg/ng got %b expected 000", {busy[1], pg[1], ng[1]});
        end
    endtask

    task automatic test_back_to_back();
        int hold;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            in_req = W'($urandom);
            for (int i = 0; i < W; i++) tri_en[i] = ($urandom_range(0, 4) == 0);
            hold = $urandom_range(1, 6);
            repeat (hold - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_dead();
        @(negedge clk);
        in_req = 4'b0001;
        tri_en = 4'b0000;
        repeat (6) @(posedge clk);
        @(negedge clk);
        in_req[0] = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin failures++; $display("FAIL rst_mid_dead_enter: busy got %b expected 1", busy[0]); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pg, ng, busy} !== {4'hF, 4'h0, 4'h0}) begin
            failures++;
            $display("FAIL rst_mid_dead_async: pg/ng/busy got %h/%h/%h expected f/0/0", pg, ng, busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({pg, ng, busy} !== {4'hF, 4'hF, 4'h0}) begin
            failures++;
            $display("FAIL rst_mid_dead_restart: pg/ng/busy got %h/%h/%h expected f/f/0", pg, ng, busy);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_dead_time();
        test_mid_dead_toggle();
        test_hiz();
        test_back_to_back();
        test_reset_mid_dead();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
